// File: rtl/ft_slv_fifo_rsp.sv
// FT600 245-mode responder: answers master WR_N/RD_N/OE_N and loops written words back through a FIFO.
// Optional `define SLV_STREAM_EN adds a 'stream' input that replaces read data with a free-running counter.
module ft_slv_fifo_rsp #(
    parameter int AW         = 9,
    parameter int TXE_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic        oe_n,
    input  logic [31:0] idata,
    input  logic [3:0]  ibe,
`ifdef SLV_STREAM_EN
    input  logic        stream,
`endif
    output logic        txe_n,
    output logic        rxf_n,
    output logic [31:0] odata,
    output logic [3:0]  obe,
    output logic        dt_oe,
    output logic        ovf,
    output logic        udf
);

    localparam int         DEPTH     = 1 << AW;
    localparam logic [AW:0] C_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_TXE_LIM = (AW+1)'(DEPTH - TXE_MARGIN);

    logic [35:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_txe_n;
    logic          r_rxf_n;
    logic [31:0]   r_odata;
    logic [3:0]    r_obe;
    logic          r_ovf;
    logic          r_udf;

    logic          w_stream;
    logic          w_push_req;
    logic          w_pop_req;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [AW-1:0] w_rptr_next;
    logic [AW:0]   w_count_next;
    logic [35:0]   w_head;
    logic [31:0]   w_odata_next;
    logic [3:0]    w_obe_next;

`ifdef SLV_STREAM_EN
    logic          r_stream_d;
    logic [31:0]   r_scnt;
    logic [31:0]   w_scnt_next;

    assign w_stream = stream;

    // Counter restarts on a stream rising edge so the first read after enabling returns 0.
    always_comb begin
        w_scnt_next = r_scnt;
        if (stream && !r_stream_d)
            w_scnt_next = '0;
        else if (stream && !rd_n && !oe_n)
            w_scnt_next = r_scnt + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stream_d <= 1'b0;
            r_scnt     <= '0;
        end else begin
            r_stream_d <= stream;
            r_scnt     <= w_scnt_next;
        end
    end
`else
    assign w_stream = 1'b0;
`endif

    always_comb begin
        w_push_req   = ~wr_n & ~w_stream;
        w_pop_req    = ~rd_n & ~oe_n & ~w_stream;
        w_full       = (r_count == C_FULL);
        w_empty      = (r_count == '0);
        w_wr_ok      = w_push_req & ~w_full;
        w_rd_ok      = w_pop_req & ~w_empty;
        w_rptr_next  = r_rptr + AW'(w_rd_ok);
        w_count_next = r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
        // A word written this edge into the slot about to become head must bypass the array.
        if (w_wr_ok && (r_wptr == w_rptr_next))
            w_head = {ibe, idata};
        else
            w_head = r_mem[w_rptr_next];
    end

    always_comb begin
        w_odata_next = '0;
        w_obe_next   = '0;
        if (w_count_next != '0) begin
            w_odata_next = w_head[31:0];
            w_obe_next   = w_head[35:32];
        end
`ifdef SLV_STREAM_EN
        if (stream) begin
            w_odata_next = w_scnt_next;
            w_obe_next   = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_mem[r_wptr] <= {ibe, idata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_txe_n <= 1'b1;
            r_rxf_n <= 1'b1;
            r_odata <= '0;
            r_obe   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr_ok)
                r_wptr <= r_wptr + AW'(1);
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
            r_txe_n <= ~w_stream & (w_count_next > C_TXE_LIM);
            r_rxf_n <= ~w_stream & (w_count_next == '0);
            r_odata <= w_odata_next;
            r_obe   <= w_obe_next;
            r_ovf   <= r_ovf | (w_push_req & w_full);
            r_udf   <= r_udf | (w_pop_req & w_empty);
        end
    end

    assign txe_n = r_txe_n;
    assign rxf_n = r_rxf_n;
    assign odata = r_odata;
    assign obe   = r_obe;
    assign ovf   = r_ovf;
    assign udf   = r_udf;
    assign dt_oe = ~oe_n & ~rst;

endmodule

// File: tb/tb_ft_slv_fifo_rsp.sv
// Directed self-checking bench for ft_slv_fifo_rsp with an 8-deep FIFO (AW=3, TXE_MARGIN=2).
// Stream-mode vectors are included only when SLV_STREAM_EN is defined.
module tb_ft_slv_fifo_rsp;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_n;
    logic        rd_n;
    logic        oe_n;
    logic [31:0] idata;
    logic [3:0]  ibe;
`ifdef SLV_STREAM_EN
    logic        stream;
`endif
    logic        txe_n;
    logic        rxf_n;
    logic [31:0] odata;
    logic [3:0]  obe;
    logic        dt_oe;
    logic        ovf;
    logic        udf;

    int vectorCount = 0;
    int missCount   = 0;

    ft_slv_fifo_rsp #(.AW(3), .TXE_MARGIN(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_n  (wr_n),
        .rd_n  (rd_n),
        .oe_n  (oe_n),
        .idata (idata),
        .ibe   (ibe),
`ifdef SLV_STREAM_EN
        .stream(stream),
`endif
        .txe_n (txe_n),
        .rxf_n (rxf_n),
        .odata (odata),
        .obe   (obe),
        .dt_oe (dt_oe),
        .ovf   (ovf),
        .udf   (udf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic r, input logic o,
                                 input logic [31:0] d, input logic [3:0] b);
        wr_n  = w;
        rd_n  = r;
        oe_n  = o;
        idata = d;
        ibe   = b;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
`ifdef SLV_STREAM_EN
        stream = 1'b0;
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        tick();
        tick();
        checkOutput("rst_txe_n", txe_n, 1);
        checkOutput("rst_rxf_n", rxf_n, 1);
        checkOutput("rst_odata", odata, 0);
        checkOutput("rst_obe", obe, 0);
        checkOutput("rst_dt_oe_gated", dt_oe, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_udf", udf, 0);
        oe_n = 1'b1;
        rst  = 1'b0;
        tick();
        checkOutput("idle_txe_n", txe_n, 0);
        checkOutput("idle_rxf_n", rxf_n, 1);
        checkOutput("idle_odata", odata, 0);
        checkOutput("idle_dt_oe", dt_oe, 0);

        // Four-word loopback.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h11111111 * (k + 1), 4'hF);
            tick();
            if (k == 0) begin
                checkOutput("wr4_rxf_first", rxf_n, 0);
                checkOutput("wr4_odata_first", odata, 32'h11111111);
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        #1;
        checkOutput("wr4_dt_oe", dt_oe, 1);
        rd_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rd4_odata%0d", k), odata, 32'h11111111 * (k + 1));
            checkOutput($sformatf("rd4_obe%0d", k), obe, 4'hF);
            checkOutput($sformatf("rd4_rxf%0d", k), rxf_n, 0);
            tick();
        end
        checkOutput("rd4_rxf_end", rxf_n, 1);
        checkOutput("rd4_odata_end", odata, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'h0);

        // Overfill: 9 writes into 8 slots, txe_n rises once count reaches 7.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'hA0000000 + i, 4'hF);
            tick();
            checkOutput($sformatf("ovf_txe%0d", i), txe_n, (i >= 6) ? 1 : 0);
            checkOutput($sformatf("ovf_flag%0d", i), ovf, (i == 8) ? 1 : 0);
            checkOutput($sformatf("ovf_head%0d", i), odata, 32'hA0000000);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("ovf_rd%0d", j), odata, 32'hA0000000 + j);
            tick();
        end
        checkOutput("ovf_rd_rxf_end", rxf_n, 1);
        checkOutput("ovf_rd_odata_end", odata, 0);
        checkOutput("ovf_rd_txe_end", txe_n, 0);
        checkOutput("ovf_rd_udf", udf, 0);

        // Simultaneous push and pop with count at 1.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hB1B1B1B1, 4'h3);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'hB2B2B2B2, 4'hF);
        checkOutput("sim_odata_first", odata, 32'hB1B1B1B1);
        checkOutput("sim_obe_first", obe, 4'h3);
        tick();
        checkOutput("sim_rxf", rxf_n, 0);
        checkOutput("sim_odata_second", odata, 32'hB2B2B2B2);
        checkOutput("sim_obe_second", obe, 4'hF);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        checkOutput("sim_rxf_end", rxf_n, 1);
        checkOutput("sim_odata_end", odata, 0);

        // Pop on empty: underflow, no pointer movement.
        tick();
        checkOutput("udf_flag", udf, 1);
        checkOutput("udf_odata", odata, 0);
        checkOutput("udf_rxf", rxf_n, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hC1C1C1C1, 4'hC);
        tick();
        checkOutput("udf_after_wr_odata", odata, 32'hC1C1C1C1);
        checkOutput("udf_after_wr_obe", obe, 4'hC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        checkOutput("udf_after_rd_rxf", rxf_n, 1);
        checkOutput("ovf_sticky", ovf, 1);
        checkOutput("udf_sticky", udf, 1);

        // Reset in the middle of a 5-word burst.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'hD0000000 + i, 4'hF);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 4'h0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_txe", txe_n, 1);
        checkOutput("mid_rst_rxf", rxf_n, 1);
        checkOutput("mid_rst_odata", odata, 0);
        checkOutput("mid_rst_ovf", ovf, 0);
        checkOutput("mid_rst_udf", udf, 0);
        checkOutput("mid_rst_dt_oe", dt_oe, 0);
        tick();
        oe_n = 1'b1;
        rst  = 1'b0;
        tick();
        checkOutput("post_rst_txe", txe_n, 0);
        checkOutput("post_rst_rxf", rxf_n, 1);
        checkOutput("post_rst_odata", odata, 0);
        for (int i = 3; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'hD0000000 + i, 4'hF);
            tick();
        end
        checkOutput("post_rst_head", odata, 32'hD0000003);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        checkOutput("post_rst_second", odata, 32'hD0000004);
        tick();
        checkOutput("post_rst_drained", rxf_n, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'h0);

`ifdef SLV_STREAM_EN
        // Stream mode: counter read data, FIFO bypassed.
        stream = 1'b1;
        tick();
        checkOutput("str_rxf_start", rxf_n, 0);
        checkOutput("str_txe_start", txe_n, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("str_odata%0d", j), odata, j);
            checkOutput($sformatf("str_obe%0d", j), obe, 4'hF);
            checkOutput($sformatf("str_rxf%0d", j), rxf_n, 0);
            tick();
        end
        checkOutput("str_odata3", odata, 3);
        checkOutput("str_udf", udf, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hEEEEEEEE, 4'hF);
        for (int i = 0; i < 10; i++)
            tick();
        checkOutput("str_wr_ovf", ovf, 0);
        checkOutput("str_wr_txe", txe_n, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'h0);
        stream = 1'b0;
        tick();
        checkOutput("str_off_rxf", rxf_n, 1);
        stream = 1'b1;
        tick();
        checkOutput("str_restart_odata", odata, 0);
        stream = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/ft_slv_fifo_rsp.md
Name: ft_slv_fifo_rsp

Overview:
Synthesizable FT600-side responder for the 245-mode Master FIFO bus. It is the slave end of the same bus the FPGA master drives. It answers WR_N/RD_N/OE_N with TXE_N/RXF_N, stores master-written words with their byte enables in an internal loopback FIFO, and returns them on master reads. Used as an on-chip or bench counterpart for loopback bring-up. Single channel only; no multi-channel mode.

Parameters:
AW, 9, log2 of loopback FIFO depth (DEPTH = 2^AW words of 36 bits: data + BE)
TXE_MARGIN, 2, free-slot margin at which txe_n deasserts; covers master stop latency

Ports:
clk  in  1  bus clock (FT600 CLK)
rst  in  1  asynchronous, active-high reset
wr_n  in  1  master write strobe, active low
rd_n  in  1  master read strobe, active low
oe_n  in  1  master output-enable request, active low
idata  in  32  data driven by master during writes
ibe  in  4  byte enables driven by master during writes
txe_n  out  1  low = responder can accept writes
rxf_n  out  1  low = responder has read data
odata  out  32  read data presented to master
obe  out  4  read byte enables presented to master
dt_oe  out  1  drive enable for odata/obe; top level builds the tristate
ovf  out  1  sticky: write attempted while FIFO full
udf  out  1  sticky: pop attempted while FIFO empty

Behaviour:
- One clock; reset is asynchronous and active-high: clk, rst.
- Reset values: txe_n=1, rxf_n=1, odata=0, obe=0, ovf=0, udf=0, pointers=0, count=0. dt_oe is held 0 while rst=1.
- count is AW+1 bits wide, range 0..DEPTH. Read and write pointers are AW bits and wrap modulo DEPTH.
- Push: at a rising edge with wr_n=0, {ibe,idata} is written at wptr if count<DEPTH. If count==DEPTH, the word is dropped and ovf sets. txe_n is not qualified, so the margin absorbs master latency.
- Pop: at a rising edge with rd_n=0 and oe_n=0, rptr advances if count>0. If count==0, nothing happens and udf sets.
- Simultaneous push and pop: both take effect and count is unchanged. The empty/full checks use the pre-edge count, so a pop at count==0 is never satisfied by a same-cycle push.
- count_next = count + push - pop.
- txe_n is registered: txe_n <= (count_next > DEPTH - TXE_MARGIN).
- rxf_n is registered: rxf_n <= (count_next == 0).
- odata/obe are registered, first-word fall-through. When count_next>0 they load mem[rptr_next]; otherwise 0.
  - A word pushed into an empty FIFO appears on odata one edge later, on the same edge that rxf_n goes low.
  - After each pop, the next word is valid the following cycle.
- dt_oe = ~oe_n & ~rst, combinational. The responder drives the bus in the cycle oe_n is low. The master's first rd_n-low edge consumes the word currently on odata.
- A write while oe_n=0 is a master protocol error. It is still accepted as a push; no bus contention handling is done here.
- Reset mid-burst: all state clears immediately and FIFO contents are discarded. After rst falls, txe_n goes 0 at the first edge and rxf_n stays 1.
- ovf and udf clear only on rst.

Optional Feature:
- Macro: SLV_STREAM_EN.
- With the macro defined:
  - Add input port stream (1 bit).
  - When stream=1, the read path ignores the FIFO and returns a free-running 32-bit counter. It starts at 0 after rst or on a stream 0->1 transition, increments on each pop, and drives obe=4'hF.
  - rxf_n is held 0 and udf never sets.
  - Writes are accepted and discarded; txe_n is held 0 and ovf never sets.
  - stream=0 gives pure loopback.
- Without the macro: no stream port, loopback only.

Test Plan:
- Reset, then idle -> txe_n=0 after first edge, rxf_n=1, odata=0, dt_oe=0.
- Write 4 words 0x11111111..0x44444444 with ibe=4'hF, then oe_n=0 and rd_n=0 for 4 cycles -> rxf_n=0 one edge after the first write; odata sequence 0x11111111..0x44444444 with obe=4'hF; rxf_n=1 after the last pop.
- AW=3, TXE_MARGIN=2, write 9 words back to back ignoring txe_n -> txe_n=1 once count reaches 7; 8 words stored; 9th dropped; ovf=1; readback returns the first 8 words only.
- Write one word with ibe=4'h3 and read it while simultaneously writing a second word -> first read gives obe=4'h3; count stays 1; rxf_n stays 0; second word follows.
- rd_n=0 and oe_n=0 with FIFO empty -> no pointer change, udf=1, odata=0. Assert rst mid-burst of 5 words -> all outputs return to reset values; no stale data after release.
- SLV_STREAM_EN, stream=1, 3 pops -> odata 0,1,2, obe=4'hF, rxf_n=0 throughout; toggle stream 0->1 -> counter restarts at 0.
